// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, shadow-entry type and interlock state for the five-stage core
package pipeline_pkg;

    localparam int REG_ADDR_W   = 3;
    localparam int DATA_W       = 16;
    localparam int SHADOW_DEPTH = 3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  write;
        logic                  load;
    } shadow_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hazard_state_e;

    // True when a p2 source reads the destination of a load still sitting in p3.
    function automatic logic load_use(input shadow_entry_t e,
                                      input logic use_src,
                                      input logic [REG_ADDR_W-1:0] addr);
        return use_src & e.valid & e.write & e.load & (addr == e.dest);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - p2 issue/source bundle plus interlock outputs and shadow view
interface hazard_stall_unit_if;
    import pipeline_pkg::*;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_dest;
    logic                  issue_write;
    logic                  issue_load;
    logic [REG_ADDR_W-1:0] src_addr_A;
    logic [REG_ADDR_W-1:0] src_addr_B;
    logic                  src_use_A;
    logic                  src_use_B;
    logic                  mem_busy;
    logic                  flush;
    logic                  stall;
    logic                  bubble;
    shadow_entry_t [SHADOW_DEPTH-1:0] shadow;

    modport master (
        output issue_valid, issue_dest, issue_write, issue_load,
        output src_addr_A, src_addr_B, src_use_A, src_use_B,
        output mem_busy, flush,
        input  stall, bubble, shadow
    );

    modport slave (
        input  issue_valid, issue_dest, issue_write, issue_load,
        input  src_addr_A, src_addr_B, src_use_A, src_use_B,
        input  mem_busy, flush,
        output stall, bubble, shadow
    );

endinterface

// File: rtl/stall_counter.sv
// rtl/stall_counter.sv - saturating up-counter with enable, cleared only by reset
module stall_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use interlock over a p3/p4/p5 shadow pipeline; HAZARD_STALL_COUNT_EN adds the stall counter
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int DEPTH = SHADOW_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    hazard_stall_unit_if.slave p2,
    output logic [CNT_W-1:0]   stall_count
);

    shadow_entry_t [DEPTH-1:0] shadow_q;
    shadow_entry_t [DEPTH-1:0] shadow_d;
    hazard_state_e             state_q;
    hazard_state_e             state_d;
    logic                      bubble_q;
    logic                      bubble_d;
    logic                      load_hazard;
    logic                      stall;

    always_comb begin
        load_hazard = load_use(shadow_q[0], p2.src_use_A, p2.src_addr_A)
                    | load_use(shadow_q[0], p2.src_use_B, p2.src_addr_B);
        // A taken branch squashes p2, so holding it would be pointless; a busy back end wins over both.
        stall = ~reset & (p2.mem_busy | (load_hazard & ~p2.flush));
    end

    always_comb begin
        shadow_d = shadow_q;
        bubble_d = bubble_q;
        state_d  = state_q;

        case (state_q)
            RUN:     if (p2.mem_busy)  state_d = HOLD;
            HOLD:    if (!p2.mem_busy) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (!p2.mem_busy) begin
            for (int i = DEPTH - 1; i > 0; i = i - 1) begin
                shadow_d[i] = shadow_q[i-1];
            end
            if (p2.flush || load_hazard) begin
                shadow_d[0] = '0;
                bubble_d    = 1'b1;
            end else begin
                shadow_d[0] = '{valid: p2.issue_valid, dest: p2.issue_dest,
                                write: p2.issue_write, load: p2.issue_load};
                bubble_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q <= '0;
            state_q  <= RUN;
            bubble_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    assign p2.stall  = stall;
    assign p2.bubble = bubble_q;
    assign p2.shadow = shadow_q;

`ifdef HAZARD_STALL_COUNT_EN
    stall_counter #(
        .W (CNT_W)
    ) u_stall_counter (
        .clock (clock),
        .reset (reset),
        .en    (stall),
        .count (stall_count)
    );
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit and the saturating stall counter
module tb_hazard_stall_unit;
    import pipeline_pkg::*;

    typedef struct {
        string       tag;
        logic        stall;
        logic        bubble;
        int unsigned count;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [15:0] stall_count;
    logic        sat_reset;
    logic        sat_en;
    logic [1:0]  sat_count;

    exp_t        sb[$];
    int unsigned exp_count;
    int          checks;
    int          failures;

    hazard_stall_unit_if hif ();

    hazard_stall_unit #(
        .DEPTH (SHADOW_DEPTH),
        .CNT_W (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .p2          (hif.slave),
        .stall_count (stall_count)
    );

    stall_counter #(
        .W (2)
    ) u_sat (
        .clock (clock),
        .reset (sat_reset),
        .en    (sat_en),
        .count (sat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag,
                       input logic v, input logic [2:0] d, input logic w, input logic l,
                       input logic [2:0] a, input logic ua, input logic [2:0] b, input logic ub,
                       input logic mb, input logic fl, input logic rs,
                       input logic es, input logic eb);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = rs;
        hif.issue_valid = v;
        hif.issue_dest  = d;
        hif.issue_write = w;
        hif.issue_load  = l;
        hif.src_addr_A  = a;
        hif.src_use_A   = ua;
        hif.src_addr_B  = b;
        hif.src_use_B   = ub;
        hif.mem_busy    = mb;
        hif.flush       = fl;
        e.tag    = tag;
        e.stall  = es;
        e.bubble = eb;
        e.count  = exp_count;
        sb.push_back(e);
        #3;
        e = sb.pop_front();
        chk({e.tag, ".stall"},  {31'd0, hif.stall},  {31'd0, e.stall});
        chk({e.tag, ".bubble"}, {31'd0, hif.bubble}, {31'd0, e.bubble});
`ifdef HAZARD_STALL_COUNT_EN
        chk({e.tag, ".count"}, {16'd0, stall_count}, e.count);
`else
        chk({e.tag, ".count"}, {16'd0, stall_count}, 32'd0);
`endif
        if (rs) exp_count = 0;
        else if (e.stall) exp_count++;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 0;
        reset     = 1'b1;
        sat_reset = 1'b1;
        sat_en    = 1'b0;
        hif.issue_valid = 1'b0; hif.issue_dest = '0; hif.issue_write = 1'b0; hif.issue_load = 1'b0;
        hif.src_addr_A  = '0;   hif.src_use_A  = 1'b0; hif.src_addr_B = '0;  hif.src_use_B = 1'b0;
        hif.mem_busy    = 1'b1; hif.flush      = 1'b0;

        //   tag           v  d  w  l   a  ua b  ub  mb fl rs  stall bubble
        cyc("rst",         0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1,  0, 0);
        cyc("rst_rel",     0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        chk("rst.shadow", {14'd0, hif.shadow}, 32'd0);
        cyc("lu_issue",    1, 3, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("lu_stall",    1, 1, 1, 0,  3, 1, 0, 0,  0, 0, 0,  1, 0);
        cyc("lu_held",     1, 1, 1, 0,  3, 1, 0, 0,  0, 0, 0,  0, 1);
        cyc("lu_after",    0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("fw_issue",    1, 3, 1, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("fw_readA",    1, 4, 1, 0,  3, 1, 0, 0,  0, 0, 0,  0, 0);
        cyc("fw_readB",    0, 0, 0, 0,  0, 0, 4, 1,  0, 0, 0,  0, 0);
        cyc("mask_issue",  1, 5, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("mask_read",   1, 0, 0, 0,  5, 0, 5, 0,  0, 0, 0,  0, 0);
        cyc("b_issue",     1, 5, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("b_stall",     0, 0, 0, 0,  0, 0, 5, 1,  0, 0, 0,  1, 0);
        cyc("b_held",      0, 0, 0, 0,  0, 0, 5, 1,  0, 0, 0,  0, 1);
        cyc("r0_issue",    1, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("r0_stall",    0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0,  1, 0);
        cyc("r0_held",     0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0,  0, 1);
        cyc("mb_issue",    1, 2, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("mb1",         0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0);
        cyc("mb2",         0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0);
        cyc("mb3",         0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0);
        cyc("mb_rel",      0, 0, 0, 0,  2, 1, 0, 0,  0, 0, 0,  1, 0);
        chk("mb_rel.p3", {14'd0, hif.shadow[0]}, {26'd0, 1'b1, 3'd2, 1'b1, 1'b1});
        cyc("mb_after",    0, 0, 0, 0,  2, 1, 0, 0,  0, 0, 0,  0, 1);
        cyc("fl_issue",    1, 6, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("fl_hit",      1, 1, 1, 0,  6, 1, 0, 0,  0, 1, 0,  0, 0);
        cyc("fl_after",    0, 0, 0, 0,  6, 1, 0, 0,  0, 0, 0,  0, 1);
        chk("fl_after.p3_valid", {31'd0, hif.shadow[0].valid}, 32'd0);
        chk("fl_after.p4",       {14'd0, hif.shadow[1]}, {26'd0, 1'b1, 3'd6, 1'b1, 1'b1});
        cyc("fm_issue",    1, 1, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("fm_busy",     0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 0,  1, 0);
        cyc("fm_rel",      0, 0, 0, 0,  1, 1, 0, 0,  0, 1, 0,  0, 0);
        cyc("fm_after",    0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1);
        chk("fm_after.p3_valid", {31'd0, hif.shadow[0].valid}, 32'd0);
        chk("fm_after.p4_dest",  {29'd0, hif.shadow[1].dest}, 32'd1);
        cyc("rh_issue",    1, 7, 1, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
        cyc("rh_busy",     0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0);
        chk("rh_busy.p3_dest",   {29'd0, hif.shadow[0].dest}, 32'd7);
        cyc("rh_reset",    0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1,  0, 0);
        cyc("rh_read",     0, 0, 0, 0,  7, 1, 0, 0,  0, 0, 0,  0, 0);
        chk("rh_read.shadow", {14'd0, hif.shadow}, 32'd0);
        cyc("rh_idle",     0, 0, 0, 0,  7, 1, 0, 0,  0, 0, 0,  0, 0);

        // Narrow counter driven past its ceiling must stick at all-ones.
        @(posedge clock);
        #1;
        sat_reset = 1'b0;
        sat_en    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            #4;
            chk($sformatf("sat.%0d", k), {30'd0, sat_count}, (k > 3) ? 32'd3 : k);
        end
        sat_en = 1'b0;

        if (sb.size() != 0) chk("sb.empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
